// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave responder.
package spi_slave_pkg;
  typedef enum logic {IDLE, ACTIVE} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_slave_responder_if.sv
// Pad-side SPI pins plus TX/RX character streams of the SPI slave responder.
interface spi_slave_responder_if #(
  parameter int SS_NB    = 8,
  parameter int CHAR_LEN = 8
);
  logic [SS_NB-1:0]    ss_pad_i;
  logic                sclk_pad_i;
  logic                mosi_pad_i;
  logic                miso_pad_o;
  logic [CHAR_LEN-1:0] tx_data_i;
  logic                tx_valid_i;
  logic                tx_ready_o;
  logic [CHAR_LEN-1:0] rx_data_o;
  logic                rx_valid_o;
  logic                rx_ready_i;
  logic                rx_overrun_o;
  logic                tx_underrun_o;
  logic                frame_abort_o;
  logic                busy_o;

  modport slave (
    input  ss_pad_i, sclk_pad_i, mosi_pad_i, tx_data_i, tx_valid_i, rx_ready_i,
    output miso_pad_o, tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o,
           tx_underrun_o, frame_abort_o, busy_o
  );
  modport master (
    output ss_pad_i, sclk_pad_i, mosi_pad_i, tx_data_i, tx_valid_i, rx_ready_i,
    input  miso_pad_o, tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o,
           tx_underrun_o, frame_abort_o, busy_o
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one pad input plus a flop for rise/fall detection.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {3{RST_VAL}};
    else        s <= {s[1:0], d};

  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave_responder.sv
// Oversampling SPI slave: deserialises MOSI to a valid/ready RX port and
// serialises characters from a one-deep TX buffer onto MISO.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int SS_NB     = 8,
  parameter int SS_SEL    = 0,
  parameter int CHAR_LEN  = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0,
  parameter logic [CHAR_LEN-1:0] TX_IDLE = '1
) (
  input logic wb_clk_i,
  input logic wb_rst_n_i,
  spi_slave_responder_if.slave bus
);
  localparam int CW  = clog2(CHAR_LEN);
  localparam int SEL = (SS_SEL < SS_NB) ? SS_SEL : 0;
  localparam logic [CW-1:0] LAST = CW'(CHAR_LEN - 1);
  // ss idles deasserted and sclk at its idle level so reset release creates no edges
  localparam logic [2:0] SYNC_RST = {1'b1, CPOL != 0, 1'b0};

  logic [2:0] pin_d, pin_q, pin_rise, pin_fall;
  assign pin_d = {bus.ss_pad_i[SEL], bus.sclk_pad_i, bus.mosi_pad_i};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    spi_pin_sync #(.RST_VAL(SYNC_RST[i])) u_sync (
      .clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(pin_d[i]),
      .q(pin_q[i]), .rise(pin_rise[i]), .fall(pin_fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{pin_rise[2], pin_fall[2], pin_rise[0], pin_fall[0], pin_q[1]};

  logic ss_n, mosi_s, lead, trail, smp, drv;
  assign ss_n   = pin_q[2];
  assign mosi_s = pin_q[0];
  assign lead   = (CPOL != 0) ? pin_fall[1] : pin_rise[1];
  assign trail  = (CPOL != 0) ? pin_rise[1] : pin_fall[1];
  assign smp    = (CPHA != 0) ? trail : lead;
  assign drv    = (CPHA != 0) ? lead  : trail;

  state_e              state;
  logic [CHAR_LEN-1:0] tx_buf, tx_shift, rx_shift, rx_data, load_word, rx_word;
  logic [CW-1:0]       bit_cnt;
  logic                tx_full, rx_valid, miso, rx_overrun, tx_underrun, frame_abort;
  logic                load, tx_acc;

  function automatic logic first_bit(input logic [CHAR_LEN-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[CHAR_LEN-1];
  endfunction

  function automatic logic [CHAR_LEN-1:0] shift_out(input logic [CHAR_LEN-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign tx_acc    = bus.tx_valid_i && !tx_full;
  assign load_word = tx_full ? tx_buf : TX_IDLE;
  assign rx_word   = (LSB_FIRST != 0) ? {mosi_s, rx_shift[CHAR_LEN-1:1]}
                                      : {rx_shift[CHAR_LEN-2:0], mosi_s};
  assign load      = !ss_n && ((state == IDLE) || (smp && bit_cnt == LAST));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      if (tx_acc) begin
        tx_buf  <= bus.tx_data_i;
        tx_full <= 1'b1;
      end
      if (rx_valid && bus.rx_ready_i) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (!ss_n) state <= ACTIVE;
        end
        ACTIVE: begin
          if (ss_n) begin
            state    <= IDLE;
            miso     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            if (bit_cnt != '0) frame_abort <= 1'b1;
          end else begin
            if (smp) begin
              rx_shift <= rx_word;
              bit_cnt  <= bit_cnt + 1'b1;
              // an accept in this same cycle frees the slot for the new word
              if (bit_cnt == LAST) begin
                if (!rx_valid || bus.rx_ready_i) begin
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                end else rx_overrun <= 1'b1;
              end
            end
            // CPHA=0: the trailing edge right after a load still belongs to the old char
            if (drv && (CPHA != 0 || bit_cnt != '0)) begin
              miso     <= first_bit(tx_shift);
              tx_shift <= shift_out(tx_shift);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        bit_cnt     <= '0;
        tx_underrun <= !tx_full;
        if (tx_full) tx_full <= 1'b0;
        if (CPHA != 0) tx_shift <= load_word;
        else begin
          tx_shift <= shift_out(load_word);
          miso     <= first_bit(load_word);
        end
      end
    end
  end

  assign bus.miso_pad_o    = miso;
  assign bus.tx_ready_o    = !tx_full;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.rx_overrun_o  = rx_overrun;
  assign bus.tx_underrun_o = tx_underrun;
  assign bus.frame_abort_o = frame_abort;
  assign bus.busy_o        = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench: mode-0 and mode-3 slaves driven by a bit-banged SPI master, sclk = clk/8.
module tb_spi_slave_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit         sel;
  logic [7:0] ss_vec, tx_data;
  logic       sclk, mosi, tx_valid, rx_ready;

  spi_slave_responder_if #(.SS_NB(8), .CHAR_LEN(8)) b0 ();
  spi_slave_responder_if #(.SS_NB(8), .CHAR_LEN(8)) b1 ();

  assign b0.ss_pad_i   = sel ? 8'hFF : ss_vec;
  assign b0.sclk_pad_i = sel ? 1'b0 : sclk;
  assign b0.mosi_pad_i = mosi;
  assign b0.tx_data_i  = tx_data;
  assign b0.tx_valid_i = !sel && tx_valid;
  assign b0.rx_ready_i = !sel && rx_ready;
  assign b1.ss_pad_i   = sel ? ss_vec : 8'hFF;
  assign b1.sclk_pad_i = sel ? sclk : 1'b1;
  assign b1.mosi_pad_i = mosi;
  assign b1.tx_data_i  = tx_data;
  assign b1.tx_valid_i = sel && tx_valid;
  assign b1.rx_ready_i = sel && rx_ready;

  logic       miso, tx_ready, rx_valid, busy, under, over, abrt;
  logic [7:0] rx_data;
  assign miso     = sel ? b1.miso_pad_o    : b0.miso_pad_o;
  assign tx_ready = sel ? b1.tx_ready_o    : b0.tx_ready_o;
  assign rx_valid = sel ? b1.rx_valid_o    : b0.rx_valid_o;
  assign rx_data  = sel ? b1.rx_data_o     : b0.rx_data_o;
  assign busy     = sel ? b1.busy_o        : b0.busy_o;
  assign under    = sel ? b1.tx_underrun_o : b0.tx_underrun_o;
  assign over     = sel ? b1.rx_overrun_o  : b0.rx_overrun_o;
  assign abrt     = sel ? b1.frame_abort_o : b0.frame_abort_o;

  spi_slave_responder #(.CPOL(0), .CPHA(0)) u_dut0 (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b0));
  spi_slave_responder #(.CPOL(1), .CPHA(1)) u_dut1 (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b1));

  int         n_under = 0, n_over = 0, n_abort = 0;
  logic [7:0] acc_q[$];
  always @(negedge clk) begin
    if (under) n_under++;
    if (over)  n_over++;
    if (abrt)  n_abort++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  int         tests = 0, fails = 0, under_snap = 0;
  logic [7:0] rx_q[$];

  typedef struct {
    bit         sel;
    bit         push;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    int         exp_under;
  } vec_t;
  vec_t vecs[6];

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    int t = 0;
    while (!tx_ready && t < 50) begin wclk(1); t++; end
    chk("tx_ready_before_push", 32'(tx_ready), 1);
    tx_data = w; tx_valid = 1'b1;
    wclk(1);
    tx_valid = 1'b0;
  endtask

  task automatic ss_begin();
    ss_vec = 8'hFE;
    wclk(4);
  endtask

  task automatic ss_end();
    wclk(4);
    ss_vec = 8'hFF;
    wclk(6);
  endtask

  // MSB-first master; sel=0 is mode 0, sel=1 is mode 3
  task automatic xfer(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      if (!sel) begin
        mosi = mo[i];
        wclk(4);
        mi[i] = miso;
        if (i == 0) under_snap = n_under;
        sclk = 1'b1;
        wclk(4);
        sclk = 1'b0;
      end else begin
        sclk = 1'b0;
        mosi = mo[i];
        wclk(4);
        mi[i] = miso;
        if (i == 0) under_snap = n_under;
        sclk = 1'b1;
        wclk(4);
      end
    end
  endtask

  task automatic drain();
    chk("rx_word_count", 32'(acc_q.size()), 32'(rx_q.size()));
    while (acc_q.size() > 0 && rx_q.size() > 0)
      chk("rx_data", 32'(acc_q.pop_front()), 32'(rx_q.pop_front()));
    acc_q.delete();
    rx_q.delete();
  endtask

  task automatic accept(input logic [7:0] w);
    rx_q.push_back(w);
    rx_ready = 1'b1;
    wclk(1);
    rx_ready = 1'b0;
    chk("rx_valid_after_accept", 32'(rx_valid), 0);
    drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mi, mi2;
    int         b_u, b_o, b_a;
    vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'hFF, 1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFF, 1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 0};

    sel = 1'b0; ss_vec = 8'hFF; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0; tx_data = '0;
    wclk(3);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    wclk(4);

    // reset three sclk into a frame, with a second word waiting in the buffer
    push(8'h77);
    ss_begin();
    push(8'h66);
    xfer(8'hFF, 3, mi);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_miso", 32'(miso), 1);
    b_u = n_under; b_o = n_over; b_a = n_abort;
    rst_n = 1'b0;
    wclk(2);
    chk("midrst_miso", 32'(miso), 0);
    chk("midrst_tx_ready", 32'(tx_ready), 1);
    chk("midrst_rx_valid", 32'(rx_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    ss_vec = 8'hFF;
    wclk(3);
    rst_n = 1'b1;
    wclk(6);
    chk("midrst_pulses", 32'((n_under - b_u) + (n_over - b_o) + (n_abort - b_a)), 0);
    chk("postrst_rx_valid", 32'(rx_valid), 0);

    for (int k = 0; k < 6; k++) begin
      sel = vecs[k].sel;
      sclk = vecs[k].sel;
      wclk(4);
      if (vecs[k].push) push(vecs[k].tx);
      b_u = n_under; b_a = n_abort;
      ss_begin();
      xfer(vecs[k].mo, 8, mi);
      chk("busy_in_frame", 32'(busy), 1);
      ss_end();
      chk("miso_char", 32'(mi), 32'(vecs[k].exp_mi));
      chk("tx_underrun_count", 32'(under_snap - b_u), 32'(vecs[k].exp_under));
      chk("no_abort", 32'(n_abort - b_a), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_miso", 32'(miso), 0);
      wclk(5);
      chk("rx_valid_held", 32'(rx_valid), 1);
      accept(vecs[k].mo);
    end

    // two chars under one ss, second TX word pushed after the first load
    sel = 1'b0; sclk = 1'b0; rx_ready = 1'b1;
    wclk(4);
    push(8'h11);
    ss_begin();
    push(8'h22);
    xfer(8'hAB, 8, mi);
    xfer(8'hCD, 8, mi2);
    ss_end();
    rx_ready = 1'b0;
    chk("two_char_miso1", 32'(mi), 32'h11);
    chk("two_char_miso2", 32'(mi2), 32'h22);
    rx_q.push_back(8'hAB);
    rx_q.push_back(8'hCD);
    drain();

    // overrun: consumer stalled across two characters
    sel = 1'b1; sclk = 1'b1;
    wclk(4);
    b_o = n_over;
    ss_begin();
    xfer(8'h01, 8, mi);
    xfer(8'h02, 8, mi2);
    ss_end();
    chk("overrun_rx_data", 32'(rx_data), 32'h01);
    chk("overrun_rx_valid", 32'(rx_valid), 1);
    chk("overrun_pulses", 32'(n_over - b_o), 1);
    accept(8'h01);

    // abort after five sclk, then an intact frame
    sel = 1'b0; sclk = 1'b0;
    wclk(4);
    b_a = n_abort;
    ss_begin();
    xfer(8'hFF, 5, mi);
    ss_vec = 8'hFF;
    wclk(6);
    chk("abort_pulses", 32'(n_abort - b_a), 1);
    chk("abort_rx_valid", 32'(rx_valid), 0);
    chk("abort_no_rx", 32'(acc_q.size()), 0);
    ss_begin();
    xfer(8'h5A, 8, mi);
    ss_end();
    chk("post_abort_no_new_abort", 32'(n_abort - b_a), 1);
    chk("post_abort_rx_data", 32'(rx_data), 32'h5A);
    chk("post_abort_rx_valid", 32'(rx_valid), 1);
    accept(8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
